// File: rtl/current_source_pkg.sv
// Shared types and constants for the current-source array sequencer:
// FSM state encoding, analog testbus selects, nominal values and window tolerances.
package current_source_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RAMP   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FAULT  = 3'd4
  } cs_state_e;

  localparam logic [2:0] ATB_NONE         = 3'd0;
  localparam logic [2:0] ATB_SUPPLY       = 3'd1;
  localparam logic [2:0] ATB_VDD08_THERM0 = 3'd2;
  localparam logic [2:0] ATB_IREF_RED     = 3'd3;
  localparam logic [2:0] ATB_SUM          = 3'd4;

  localparam real IREF_NOM  = 500.0e-6;
  localparam real UNIT_DIV  = 2.5;
  localparam real TRIM_LSB  = 0.0025;

  localparam real IREF_TOL  = 0.10;
  localparam real VDD18_NOM = 1.8;
  localparam real VDD08_NOM = 0.8;
  localparam real VDD_TOL   = 0.05;
  localparam real VSS_NOM   = 0.0;
  localparam real VSS_TOL   = 0.050;

  // Value driven on a real net that nothing is driving (RNM high-impedance).
  localparam real RNM_HIZ   = 1.0e30;

  function automatic logic in_window(input real v, input real lo, input real hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Multiplicative gain of a source for a signed trim code.
  function automatic real trim_gain(input int code);
    return 1.0 + $itor(code) * TRIM_LSB;
  endfunction

endpackage

// File: rtl/csu_debounce.sv
// Symmetric debouncer for the supply-good flag: the output only flips after
// DEB_CYC consecutive samples that disagree with it; an agreeing sample restarts the count.
module csu_debounce
  import current_source_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic sample_i,
  output logic deb_o
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Count disagreeing samples; flip on the DEB_CYC-th one in a row.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sample_i != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sample_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and debounced flag registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/current_source_array_seq.sv
// Power-up sequencer and RNM model of a trimmed thermometer + binary current-source array.
//
//   state  | meaning
//   OFF    | powered down, all sources disabled, testbus Z
//   SETTLE | bias settling, SETTLE_CYC cycles
//   RAMP   | binaries on, one thermometer unit added per cycle
//   ACTIVE | all sources on, ready
//   FAULT  | supply/reference lost, sources off, exit only via pdb=0
module current_source_array_seq
  import current_source_pkg::*;
#(
  parameter int N_THERM    = 17,
  parameter int N_BIN      = 6,
  parameter int TRIM_W     = 5,
  parameter int SETTLE_CYC = 16,
  parameter int DEB_CYC    = 4,
  localparam int N_TRIM    = N_THERM + N_BIN + 1,
  localparam int AW        = $clog2(N_THERM + N_BIN + 1)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              pdb,
  input  real               iref_500ua,
  input  real               vddana_1p8,
  input  real               vddana_0p8,
  input  real               vssana,
  input  logic              trim_wr,
  input  logic [AW-1:0]     trim_addr,
  input  logic [TRIM_W-1:0] trim_data,
  output logic              trim_ack,
  input  logic [2:0]        atb_sel,
  output real               iout_therm [N_THERM],
  output real               iout_bin [N_BIN],
  output real               iout_bin_red,
  output real               atb1,
  output real               atb0,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state_o
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = (N_THERM > 1) ? $clog2(N_THERM) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] THERM_LAST  = RW'(N_THERM - 1);
  localparam int RED_IDX = N_THERM + N_BIN;

  cs_state_e               state_q, state_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [RW-1:0]           ramp_idx_q, ramp_idx_d;
  logic                    fault_q, fault_d;
  logic                    ack_q;
  logic signed [TRIM_W-1:0] trim_q [N_TRIM];

  logic                    sup_ok;
  logic                    ok_deb;
  logic                    wr_accept;
  logic                    src_on;
  logic [N_THERM-1:0]      therm_en;
  real                     unit_cur;
  real                     sum_cur;
  int                      n_on;

  // Window check of reference current and supplies.
  always_comb begin
    sup_ok = in_window(iref_500ua, IREF_NOM * (1.0 - IREF_TOL), IREF_NOM * (1.0 + IREF_TOL))
          && in_window(vddana_1p8, VDD18_NOM * (1.0 - VDD_TOL), VDD18_NOM * (1.0 + VDD_TOL))
          && in_window(vddana_0p8, VDD08_NOM * (1.0 - VDD_TOL), VDD08_NOM * (1.0 + VDD_TOL))
          && in_window(vssana, VSS_NOM - VSS_TOL, VSS_NOM + VSS_TOL);
  end

  csu_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_deb (
    .clk      (clk),
    .rstb     (rstb),
    .sample_i (sup_ok),
    .deb_o    (ok_deb)
  );

  // Next-state logic; pdb=0 overrides everything, including fault entry.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    ramp_idx_d = ramp_idx_q;
    case (state_q)
      ST_OFF: begin
        if (ok_deb) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LAST;
        end
      end
      ST_SETTLE: begin
        if (!ok_deb) begin
          state_d = ST_FAULT;
        end else if (settle_q == '0) begin
          state_d    = ST_RAMP;
          ramp_idx_d = '0;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_RAMP: begin
        if (!ok_deb) begin
          state_d = ST_FAULT;
        end else if (ramp_idx_q == THERM_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          ramp_idx_d = ramp_idx_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!ok_deb) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
    if (!pdb) begin
      state_d    = ST_OFF;
      settle_d   = '0;
      ramp_idx_d = '0;
    end
    fault_d = (state_d == ST_FAULT);
  end

  // FSM state, timers and latched fault.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_OFF;
      settle_q   <= '0;
      ramp_idx_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      ramp_idx_q <= ramp_idx_d;
      fault_q    <= fault_d;
    end
  end

  // A held request is taken once; RAMP stalls it so trims cannot move mid-ramp.
  assign wr_accept = trim_wr && !ack_q && (state_q != ST_RAMP);

  // Trim register file; addresses beyond the last source are acked and dropped.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ack_q <= 1'b0;
      for (int k = 0; k < N_TRIM; k++) begin
        trim_q[k] <= '0;
      end
    end else begin
      ack_q <= wr_accept;
      for (int k = 0; k < N_TRIM; k++) begin
        if (wr_accept && (int'(trim_addr) == k)) begin
          trim_q[k] <= trim_data;
        end
      end
    end
  end

  // Source enables decoded straight from state so reset clears them immediately.
  always_comb begin
    src_on = (state_q == ST_RAMP) || (state_q == ST_ACTIVE);
    for (int k = 0; k < N_THERM; k++) begin
      therm_en[k] = (state_q == ST_ACTIVE) ||
                    ((state_q == ST_RAMP) && (k <= int'(ramp_idx_q)));
    end
  end

  // Source currents follow iref with no clocking; disabled sources float.
  always_comb begin
    unit_cur = iref_500ua / UNIT_DIV;
    sum_cur  = 0.0;
    n_on     = 0;
    for (int k = 0; k < N_THERM; k++) begin
      iout_therm[k] = RNM_HIZ;
      if (therm_en[k]) begin
        iout_therm[k] = unit_cur * trim_gain(int'(trim_q[k]));
        sum_cur       = sum_cur + iout_therm[k];
        n_on          = n_on + 1;
      end
    end
    for (int i = 0; i < N_BIN; i++) begin
      iout_bin[i] = RNM_HIZ;
      if (src_on) begin
        iout_bin[i] = unit_cur / $itor(1 << (N_BIN - i)) * trim_gain(int'(trim_q[N_THERM + i]));
        sum_cur     = sum_cur + iout_bin[i];
      end
    end
    iout_bin_red = RNM_HIZ;
    if (src_on) begin
      iout_bin_red = unit_cur / $itor(1 << N_BIN) * trim_gain(int'(trim_q[RED_IDX]));
      sum_cur      = sum_cur + iout_bin_red;
    end
  end

  // Analog testbus mux, only live outside OFF.
  always_comb begin
    atb1 = RNM_HIZ;
    atb0 = RNM_HIZ;
    if (state_q != ST_OFF) begin
      case (atb_sel)
        ATB_NONE: begin
          atb1 = RNM_HIZ;
          atb0 = RNM_HIZ;
        end
        ATB_SUPPLY: begin
          atb1 = vddana_1p8;
          atb0 = vssana;
        end
        ATB_VDD08_THERM0: begin
          atb1 = vddana_0p8;
          atb0 = iout_therm[0];
        end
        ATB_IREF_RED: begin
          atb1 = iref_500ua;
          atb0 = iout_bin_red;
        end
        ATB_SUM: begin
          atb1 = $itor(n_on);
          atb0 = sum_cur;
        end
        default: begin
          atb1 = RNM_HIZ;
          atb0 = RNM_HIZ;
        end
      endcase
    end
  end

  assign trim_ack = ack_q;
  assign ready    = (state_q == ST_ACTIVE);
  assign fault    = fault_q;
  assign state_o  = state_q;

endmodule

// File: doc/current_source_array_seq.md
CURRENT_SOURCE_ARRAY_SEQ -- requirements
Module: current_source_array_seq

Interface
REQ-001 SHALL have parameter N_THERM, default 17: number of thermometer unit sources.
REQ-002 SHALL have parameter N_BIN, default 6: number of binary-weighted sources, plus one redundant LSB.
REQ-003 SHALL have parameter TRIM_W, default 5: per-source signed trim width.
REQ-004 SHALL have parameter SETTLE_CYC, default 16: bias settle time in cycles. DEB_CYC, default 4: supply-monitor debounce length.
REQ-005 One clock; reset asynchronous, active-low. Ports SHALL be `clk  input  1  clock` and `rstb  input  1  asynchronous active-low reset`.
REQ-006 SHALL have `pdb  input  1  power-down negate`.
REQ-007 SHALL have real inputs `iref_500ua`, `vddana_1p8`, `vddana_0p8`, `vssana`: reference current and supplies.
REQ-008 SHALL have `trim_wr  input  1`, `trim_addr  input  $clog2(N_THERM+N_BIN+1)`, `trim_data  input  TRIM_W`, `trim_ack  output  1`: trim write handshake.
REQ-009 SHALL have `atb_sel  input  3  analog testbus select`.
REQ-010 SHALL have real outputs: `iout_therm[N_THERM]`, `iout_bin[N_BIN]`, `iout_bin_red`, `atb1`, `atb0`.
REQ-011 SHALL have `ready  output  1` (ACTIVE), `fault  output  1` (latched fault), `state_o  output  3` (FSM code).

Function
REQ-012 Window check, combinational: iref within ±10% of 500 uA, vddana_1p8/vddana_0p8 within ±5%, vssana within ±50 mV; all must pass → sup_ok.
REQ-013 Debounce: ok_deb SHALL rise after DEB_CYC consecutive good samples and fall after DEB_CYC consecutive bad samples; any opposite sample restarts the count.
REQ-014 FSM states SHALL be OFF, SETTLE, RAMP, ACTIVE, FAULT.
REQ-015 OFF→SETTLE when pdb && ok_deb. SETTLE→RAMP after exactly SETTLE_CYC cycles in SETTLE.
REQ-016 RAMP: all binary sources and the redundant source enable on the RAMP entry cycle; thermometer unit k enables on RAMP cycle k, one per cycle; RAMP→ACTIVE the cycle after unit N_THERM-1 enables.
REQ-017 pdb=0 in any state → OFF next cycle; this has priority over fault.
REQ-018 !ok_deb in SETTLE/RAMP/ACTIVE → FAULT; fault=1. FAULT exits only to OFF via pdb=0, which clears fault.
REQ-019 In OFF and FAULT all enables SHALL clear; disabled source outputs = RNM high-impedance value.
REQ-020 Enabled therm unit k = (iref_500ua/2.5)·(1 + trim_k·0.0025).
REQ-021 Enabled bin i = (iref_500ua/(2.5·2^(N_BIN-i)))·(1 + trim·0.0025). iout_bin_red uses the iout_bin[0] weight with its own trim. Outputs SHALL track iref_500ua changes with no clock delay.
REQ-022 Trim registers SHALL be two's complement (-16..15 → -4.00%..+3.75%). Addresses 0..N_THERM-1 = therm, then bin 0..N_BIN-1, last = redundant.
REQ-023 trim_wr SHALL be held until trim_ack. Write accepted in any state except RAMP; trim_ack pulses 1 cycle after acceptance. In RAMP the request stalls with no ack. Out-of-range address: acked, data discarded.
REQ-024 ATB mapping, valid only when state≠OFF, else both high-impedance:
  - 0: Z/Z
  - 1: vddana_1p8 / vssana
  - 2: vddana_0p8 / iout_therm[0]
  - 3: iref_500ua / iout_bin_red
  - 4: real(number of enabled therm units) / sum of enabled source currents
  - 5-7: Z/Z
REQ-025 state_o codes: OFF=0, SETTLE=1, RAMP=2, ACTIVE=3, FAULT=4.

Reset
REQ-026 rstb=0 SHALL immediately force: state OFF; counters 0; ok_deb 0; all trims 0; trim_ack, ready, fault 0; all real outputs high-impedance.
REQ-027 Reset mid-RAMP SHALL abort the ramp; after release, the sequence restarts from OFF with no residual enables.

Structure
REQ-028 Shared package current_source_pkg SHALL hold the state enum, ATB select constants, IREF_NOM=500e-6, UNIT_DIV=2.5, TRIM_LSB=0.0025, and tolerance constants.
REQ-029 One sub-module, csu_debounce (DEB_CYC parameter), SHALL implement REQ-013.

Verification
REQ-030 Nominal supplies, pdb 0→1: ok_deb after 4 cycles, SETTLE 16 cycles, then 17 single-cycle therm enables; ready=1 at cycle 4+16+17+1; each therm = 200 uA.
REQ-031 Write trim_addr=0, data=5'b01111 in ACTIVE: ack 1 cycle later; iout_therm[0] = 207.5 uA.
REQ-032 Write during RAMP: no ack until ACTIVE entry, then ack.
REQ-033 vddana_1p8=1.6 V for 3 cycles then 1.8 V: no fault. Held 4 cycles: FAULT, fault=1, outputs Z, then pdb=0 → OFF with fault=0.
REQ-034 atb_sel=4 in ACTIVE, nominal, zero trims: atb1=17.0, atb0 = 17·200 uA + 100+50+25+12.5+6.25+3.125+3.125 uA = 3.6 mA.
REQ-035 rstb low at RAMP cycle 5: all outputs Z immediately, trims 0; after release, full sequence repeats.
